// File: rtl/masked_and_tree.sv
// masked_and_tree: first-order (2-share, DOM-independent) masked AND of N operands, W bits each.
// Latency: L = ceil(log2(N)) cycles, one register stage per tree level; results are unmasked as o_Y0 ^ o_Y1.
// Backpressure: none. The pipeline advances every cycle, and data stages load whether or not the slot is valid.
//
// Ports:
//   clk, rst         rising-edge clock, synchronous active-high reset
//   i_valid          an operand/randomness set is presented this cycle
//   i_A0, i_A1       share 0 / share 1 of the operands; operand k = [k*W +: W]
//   i_r              fresh randomness; gadget g (breadth-first numbering) uses [g*W +: W]
//   o_valid          o_Y0/o_Y1 hold the result of the set accepted L cycles earlier
//   o_Y0, o_Y1       output shares of the AND of all N operands
module masked_and_tree #(
   parameter int N = 3,
   parameter int W = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_valid,
   input  logic [N*W-1:0]       i_A0,
   input  logic [N*W-1:0]       i_A1,
   input  logic [(N-1)*W-1:0]   i_r,
   output logic                 o_valid,
   output logic [W-1:0]         o_Y0,
   output logic [W-1:0]         o_Y1
);

   localparam int L = $clog2(N);

   // Number of nodes entering tree level lvl.
   function automatic int node_cnt(input int lvl);
      int c = N;
      for (int k = 0; k < lvl; k++) c = (c + 1) / 2;
      return c;
   endfunction

   // Index of the first gadget at tree level lvl (breadth-first numbering).
   function automatic int gadget_base(input int lvl);
      int c = N;
      int b = 0;
      for (int k = 0; k < lvl; k++) begin
         b = b + c / 2;
         c = (c + 1) / 2;
      end
      return b;
   endfunction

   if (N < 2 || N > 8) begin : g_bad_n
      $error("masked_and_tree: N must be in 2..8");
   end

   // Valid shift register, L deep.
   logic [L-1:0] vld_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q <= '0;
      end else begin
         vld_q[0] <= i_valid;
         for (int k = 1; k < L; k++) vld_q[k] <= vld_q[k-1];
      end
   end

   for (genvar lv = 0; lv < L; lv++) begin : g_lvl
      localparam int CI = node_cnt(lv);   // nodes in
      localparam int CO = (CI + 1) / 2;   // nodes out
      localparam int NG = CI / 2;         // gadgets at this level
      localparam int GB = gadget_base(lv);

      logic [CI*W-1:0] x0, x1;            // input shares of this level
      logic [NG*W-1:0] r_cur;             // randomness belonging to this level's transaction
      logic [NG*W-1:0] p0_d, p1_d, c0_d, c1_d;
      logic [NG*W-1:0] p0_q, p1_q, c0_q, c1_q;
      logic [CO*W-1:0] y0, y1;            // output shares of this level

      if (lv == 0) begin : g_in
         assign x0    = i_A0;
         assign x1    = i_A1;
         assign r_cur = i_r[GB*W +: NG*W];
      end else begin : g_in
         // This level's randomness is captured at acceptance and delayed lv
         // cycles, so it meets exactly the data of the same transaction.
         logic [NG*W-1:0] rd_q [lv];

         always_ff @(posedge clk) begin
            if (rst) begin
               for (int k = 0; k < lv; k++) rd_q[k] <= '0;
            end else begin
               rd_q[0] <= i_r[GB*W +: NG*W];
               for (int k = 1; k < lv; k++) rd_q[k] <= rd_q[k-1];
            end
         end

         assign x0    = g_lvl[lv-1].y0;
         assign x1    = g_lvl[lv-1].y1;
         assign r_cur = rd_q[lv-1];
      end

      // DOM gadgets: inner-domain products and re-masked cross terms are all
      // registered before recombination, so no cross-domain term leaves
      // this stage unregistered.
      always_comb begin
         p0_d = '0;
         p1_d = '0;
         c0_d = '0;
         c1_d = '0;
         for (int j = 0; j < NG; j++) begin
            p0_d[j*W +: W] = x0[2*j*W +: W] & x0[(2*j+1)*W +: W];
            p1_d[j*W +: W] = x1[2*j*W +: W] & x1[(2*j+1)*W +: W];
            c0_d[j*W +: W] = (x0[2*j*W +: W] & x1[(2*j+1)*W +: W]) ^ r_cur[j*W +: W];
            c1_d[j*W +: W] = (x1[2*j*W +: W] & x0[(2*j+1)*W +: W]) ^ r_cur[j*W +: W];
         end
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            p0_q <= '0;
            p1_q <= '0;
            c0_q <= '0;
            c1_q <= '0;
         end else begin
            p0_q <= p0_d;
            p1_q <= p1_d;
            c0_q <= c0_d;
            c1_q <= c1_d;
         end
      end

      if (CI % 2 == 1) begin : g_pass
         // Odd leftover node rides through this stage unchanged.
         logic [W-1:0] pt0_q, pt1_q;

         always_ff @(posedge clk) begin
            if (rst) begin
               pt0_q <= '0;
               pt1_q <= '0;
            end else begin
               pt0_q <= x0[(CI-1)*W +: W];
               pt1_q <= x1[(CI-1)*W +: W];
            end
         end

         assign y0 = {pt0_q, p0_q ^ c0_q};
         assign y1 = {pt1_q, p1_q ^ c1_q};
      end else begin : g_nopass
         assign y0 = p0_q ^ c0_q;
         assign y1 = p1_q ^ c1_q;
      end
   end

   assign o_valid = vld_q[L-1];
   assign o_Y0    = g_lvl[L-1].y0;
   assign o_Y1    = g_lvl[L-1].y1;

endmodule

// File: tb/tb_masked_and_tree.sv
module tb_masked_and_tree;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int   cyc      = 0;
   logic rst_seen = 1'b0;
   logic done     = 1'b0;
   int   tests    = 0;
   int   fails    = 0;

   typedef struct {
      logic [7:0] v;
      int         c;
   } exp_t;

   exp_t q3[$];
   exp_t q5[$];
   exp_t q4[$];
   exp_t q2[$];
   logic y4_log[$];

   // N=3, W=1
   logic        v3 = 0, ov3;
   logic [2:0]  a0_3 = 0, a1_3 = 0;
   logic [1:0]  r3 = 0;
   logic        y0_3, y1_3;
   // N=5, W=8
   logic        v5 = 0, ov5;
   logic [39:0] a0_5 = 0, a1_5 = 0;
   logic [31:0] r5 = 0;
   logic [7:0]  y0_5, y1_5;
   // N=4, W=1
   logic        v4 = 0, ov4;
   logic [3:0]  a0_4 = 0, a1_4 = 0;
   logic [2:0]  r4 = 0;
   logic        y0_4, y1_4;
   // N=2, W=8
   logic        v2 = 0, ov2;
   logic [15:0] a0_2 = 0, a1_2 = 0;
   logic [7:0]  r2 = 0;
   logic [7:0]  y0_2, y1_2;

   masked_and_tree #(.N(3), .W(1)) u3 (.clk(clk), .rst(rst), .i_valid(v3), .i_A0(a0_3), .i_A1(a1_3),
      .i_r(r3), .o_valid(ov3), .o_Y0(y0_3), .o_Y1(y1_3));
   masked_and_tree #(.N(5), .W(8)) u5 (.clk(clk), .rst(rst), .i_valid(v5), .i_A0(a0_5), .i_A1(a1_5),
      .i_r(r5), .o_valid(ov5), .o_Y0(y0_5), .o_Y1(y1_5));
   masked_and_tree #(.N(4), .W(1)) u4 (.clk(clk), .rst(rst), .i_valid(v4), .i_A0(a0_4), .i_A1(a1_4),
      .i_r(r4), .o_valid(ov4), .o_Y0(y0_4), .o_Y1(y1_4));
   masked_and_tree #(.N(2), .W(8)) u2 (.clk(clk), .rst(rst), .i_valid(v2), .i_A0(a0_2), .i_A1(a1_2),
      .i_r(r2), .o_valid(ov2), .o_Y0(y0_2), .o_Y1(y1_2));

   always @(posedge clk) begin
      cyc      <= cyc + 1;
      rst_seen <= rst;
   end

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
      end
   endtask

   task automatic mon(input string nm, input logic ov, input logic [7:0] y, ref exp_t q[$]);
      exp_t e;
      if (ov) begin
         if (q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL %s_unexpected: o_valid=1 at cycle %0d, expected no pending result", nm, cyc);
         end else begin
            e = q.pop_front();
            chk({nm, "_result"}, 32'(y), 32'(e.v));
            chk({nm, "_cycle"}, 32'(cyc), 32'(e.c));
         end
      end
   endtask

   // Monitor / scoreboard: the only process that compares.
   always @(negedge clk) begin
      if (done) begin
         chk("drain_n3", 32'(q3.size()), 32'd0);
         chk("drain_n5", 32'(q5.size()), 32'd0);
         chk("drain_n4", 32'(q4.size()), 32'd0);
         chk("drain_n2", 32'(q2.size()), 32'd0);
         chk("rand_log_len", 32'(y4_log.size()), 32'd8);
         if (y4_log.size() == 8) begin
            for (int r = 0; r < 4; r++) begin
               tests++;
               if (y4_log[r] === y4_log[r+4]) begin
                  fails++;
                  $display("FAIL rand_toggle_r%0d: o_Y0=%0b for r[2]=0 and r[2]=1, expected differing", r, y4_log[r]);
               end
            end
         end
         $display("[TB] %0d tests run, %0d failed", tests, fails);
         $finish;
      end else if (rst_seen) begin
         // Reset drops every transaction still in flight.
         q3.delete();
         q5.delete();
         q4.delete();
         q2.delete();
         chk("rst_out_n3", 32'({ov3, y0_3, y1_3}), 32'd0);
         chk("rst_out_n5", 32'({ov5, y0_5, y1_5}), 32'd0);
         chk("rst_out_n4", 32'({ov4, y0_4, y1_4}), 32'd0);
         chk("rst_out_n2", 32'({ov2, y0_2, y1_2}), 32'd0);
      end else begin
         mon("n3", ov3, 8'(y0_3 ^ y1_3), q3);
         mon("n5", ov5, y0_5 ^ y1_5, q5);
         mon("n4", ov4, 8'(y0_4 ^ y1_4), q4);
         mon("n2", ov2, y0_2 ^ y1_2, q2);
         if (ov4) y4_log.push_back(y0_4);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference model: unmask each operand, AND them all together.
   task automatic send3(input logic [2:0] s0, input logic [2:0] s1, input logic [1:0] r);
      exp_t e;
      logic [2:0] u;
      u   = s0 ^ s1;
      e.v = {7'd0, u[0] & u[1] & u[2]};
      e.c = cyc + 2;
      q3.push_back(e);
      a0_3 = s0; a1_3 = s1; r3 = r; v3 = 1'b1;
      tick();
      v3 = 1'b0;
   endtask

   task automatic send5(input logic [39:0] u);
      exp_t e;
      logic [63:0] s;
      s   = {$urandom(), $urandom()};
      e.v = 8'hFF;
      for (int k = 0; k < 5; k++) e.v = e.v & u[k*8 +: 8];
      e.c = cyc + 3;
      q5.push_back(e);
      a0_5 = s[39:0]; a1_5 = s[39:0] ^ u; r5 = $urandom(); v5 = 1'b1;
      tick();
      v5 = 1'b0;
   endtask

   task automatic send4(input logic [2:0] r);
      exp_t e;
      e.v = 8'd1;          // all four operands unmask to 1
      e.c = cyc + 2;
      q4.push_back(e);
      a0_4 = 4'b0110; a1_4 = 4'b1001; r4 = r; v4 = 1'b1;
      tick();
      v4 = 1'b0;
   endtask

   task automatic send2(input logic [15:0] u);
      exp_t e;
      logic [31:0] s;
      s   = $urandom();
      e.v = u[7:0] & u[15:8];
      e.c = cyc + 1;
      q2.push_back(e);
      a0_2 = s[15:0]; a1_2 = s[15:0] ^ u; r2 = 8'($urandom()); v2 = 1'b1;
      tick();
      v2 = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] s;
      logic [63:0] w;
      logic [2:0]  u;
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      tick();

      // N=3 truth table, random shares and randomness, one idle cycle between.
      for (int i = 0; i < 8; i++) begin
         s = $urandom();
         u = 3'(i);
         send3(s[2:0], s[2:0] ^ u, s[9:8]);
         tick();
      end
      send3(3'b101, 3'b010, 2'b11);
      repeat (4) tick();

      // Reset with a transaction in flight, plus an i_valid sampled with rst.
      send3(3'b111, 3'b000, 2'b01);
      rst = 1'b1;
      s = $urandom();
      send3(s[2:0], s[2:0] ^ 3'b111, s[5:4]);
      rst = 1'b0;
      repeat (5) tick();

      // N=5, W=8: 100 back-to-back transactions; bias operands toward ones.
      for (int i = 0; i < 100; i++) begin
         w = {$urandom(), $urandom()} | {$urandom(), $urandom()};
         send5(w[39:0]);
      end
      repeat (5) tick();

      // N=4 randomness sweep with fixed shares.
      for (int r = 0; r < 8; r++) send4(3'(r));
      repeat (4) tick();

      // N=2 minimum configuration.
      send2(16'hFFA5);
      send2(16'h00A5);
      for (int i = 0; i < 3; i++) begin
         s = $urandom();
         send2(s[15:0]);
      end
      repeat (3) tick();

      // Sparse valid on N=3: gaps of 0, 1 and 3 idle cycles.
      for (int i = 0; i < 4; i++) begin
         s = $urandom();
         send3(s[2:0], s[5:3], s[7:6]);
         if (i == 1) tick();
         if (i == 2) repeat (3) tick();
      end
      repeat (6) tick();

      done = 1'b1;
      repeat (5) tick();
   end

endmodule

// File: doc/masked_and_tree.md
Name: masked_and_tree

Overview:
- Parametrised, pipelined, first-order masked (2-share, DOM-independent) AND over N operands, each W bits wide.
- Successor to the fixed 3-input masked AND used in the masked-gadget test circuits.
- Builds a binary tree of 2-input DOM AND gadgets, with one register stage per tree level and a valid pipeline.
- Fresh randomness is supplied alongside each operand set and carried down the pipeline with it, so every gadget consumes bits that belong to its own transaction.

Parameters:
N  3  number of operands, 2..8
W  1  bit width of each operand (bitwise AND, lanes independent)
L  derived = ceil(log2(N))  pipeline depth / latency in cycles (local parameter, not overridable)

Ports:
clk      input   1        rising-edge clock
rst      input   1        synchronous, active-high reset
i_valid  input   1        operand/randomness set valid this cycle
i_A0     input   N*W      share 0 of operands; operand k = bits [k*W +: W]
i_A1     input   N*W      share 1 of operands, same packing
i_r      input   (N-1)*W  fresh random bits; gadget g uses [g*W +: W]
o_valid  output  1        o_Y0/o_Y1 hold a result
o_Y0     output  W        share 0 of AND of all N operands
o_Y1     output  W        share 1 of AND of all N operands

Behaviour:
- Functional invariant: o_Y0^o_Y1 = AND over k of (A0[k]^A1[k]), per bit, for the transaction accepted L cycles earlier.
- Tree structure:
  - Level 0 pairs operands (0,1), (2,3), and so on.
  - An odd leftover at any level passes through that level's register unchanged (both shares), with no randomness.
  - Level l+1 pairs the outputs of level l in index order.
- Gadget numbering: breadth-first, level 0 first, left to right. Total gadgets = N-1.
  - Example, N=3: g0 = op0·op1 at level 0; g1 = g0·op2 at level 1.
  - Example, N=5: g0 = (0,1), g1 = (2,3), op4 passes; g2 = (g0,g1), op4 passes; g3 = (g2,op4).
- DOM gadget, per bit, with inputs a, b and random r:
  - Y0 = a0b0 ^ reg(a0b1 ^ r)
  - Y1 = a1b1 ^ reg(a1b0 ^ r)
  - Both the cross-term sums and the inner-domain products are registered at the level's stage boundary, so every gadget output is a flop output.
  - No unregistered cross-domain path may reach the next level.
- Randomness transport:
  - At acceptance, i_r bits for gadgets at level l>0 are registered and shifted one stage per cycle alongside the data.
  - They are consumed exactly at their level. No random bit is used by two gadgets, and none is reused across transactions.
- Pipeline:
  - Free-running, with no stall or backpressure. Every stage advances each cycle.
  - valid shift register is L deep, and o_valid = valid[L-1].
  - Data stages load regardless of valid, so outputs while o_valid=0 are don't-care except after reset.
  - Back-to-back i_valid every cycle yields o_valid every cycle, with no bubbles and no cross-transaction mixing.
- Latency: L cycles from an i_valid sample edge to o_valid high. N=2 gives 1, N=3..4 gives 2, N=5..8 gives 3.
- Reset:
  - With rst=1 at a rising edge, all valid bits, data/share registers and randomness delay registers clear to 0.
  - Outputs therefore read o_valid=0, o_Y0=0, o_Y1=0 from the first edge after rst is sampled.
  - Asserting rst mid-pipeline drops all in-flight transactions; no result for them ever appears.
  - i_valid sampled on the same edge as rst=1 is ignored.
- Simultaneous events: input acceptance and output emission in the same cycle are independent.
- Elaboration: N<2 or N>8 triggers an elaboration error.

Test Plan:
- N=3, W=1 truth table:
  - Drive all 8 unmasked input combinations, each with random shares and random i_r.
  - Required: o_Y0^o_Y1 = A&B&C exactly 2 cycles after each i_valid, with o_valid high on that cycle only.
  - Specifically, A=B=C=1 (shares A0=1,A1=0; B0=0,B1=1; C0=1,C1=0; r=2'b11) gives o_Y0^o_Y1 = 1.
- Reset behaviour:
  - Assert rst for 1 cycle after a transaction enters.
  - Required: o_valid=0, o_Y0=0 and o_Y1=0 from the next edge, and the dropped transaction never emerges.
  - An i_valid sampled together with rst produces no output.
- N=5, W=8 streaming:
  - 100 back-to-back transactions with random shares and randomness.
  - Required: o_valid high continuously from cycle 3 to cycle 102, and every result equals the 8-bit AND of the 5 unmasked operands, in order.
- Randomness independence, N=4, W=1:
  - Fixed unmasked inputs, all 1s. Sweep i_r over all 8 values with fixed shares.
  - Required: the unmasked result is 1 for every i_r value, and o_Y0 toggles for different i_r[g*W] of the final gadget (g=2), proving randomness is used at level 1.
- N=2 minimum config:
  - Latency is 1 cycle.
  - Operands 0xA5/0xFF with W=8 give an unmasked result of 0xA5.
- Sparse valid:
  - i_valid pulses with gaps of 0, 1 and 3 idle cycles.
  - Required: o_valid pulses replicate the same gap pattern, delayed by L.
